// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bus bundle for the unified-memory arbiter. It carries three groups:
//   fetch port : if_req, if_addr -> if_rdata, if_ack, if_stall
//   data port  : dm_req, dm_we, dm_addr, dm_wdata -> dm_rdata, dm_ack, dm_stall
//   memory side: mem_req, mem_we, mem_addr, mem_wdata <- mem_rdata, mem_ack
//   status     : bus_err (pulses with the ack of an aborted access)
// Modports:
//   slave  - arbiter view (serves the pipeline ports, drives the memory)
//   master - environment view (pipeline requesters plus memory model)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ack;
   logic              if_stall;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_ack;
   logic              dm_stall;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   logic              bus_err;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
      output if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
             mem_req, mem_we, mem_addr, mem_wdata, bus_err
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
      input  if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
             mem_req, mem_we, mem_addr, mem_wdata, bus_err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between the instruction-fetch port and the
// data-memory port. Each access runs IDLE -> BUSY_IF/BUSY_DM -> RESP -> IDLE;
// a watchdog aborts a BUSY phase that sees no mem_ack for TIMEOUT cycles and
// reports it through bus_err alongside the port ack.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - mem_port_arbiter_if.slave (fetch port, data port, memory side)
// Parameters: ADDR_W, DATA_W, TIMEOUT (>= 2)
// Optional build macro ARB_RR_EN: when both ports request together, grant the
// port opposite the last grant. Without it the data port always wins a tie.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);
   localparam int               CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_DM = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              if_ack_q, if_ack_d;
   logic              dm_ack_q, dm_ack_d;
   logic              bus_err_q, bus_err_d;
   logic              grant_dm_s;

`ifdef ARB_RR_EN
   // last_dm_q = 1 when the most recent grant went to the data port.
   logic              last_dm_q, last_dm_d;

   // Tie-break: a simultaneous request goes to the port not served last time.
   always_comb begin
      grant_dm_s = 1'b0;
      if (bus.dm_req && bus.if_req) begin
         grant_dm_s = ~last_dm_q;
      end else begin
         grant_dm_s = bus.dm_req;
      end
   end

   // Last-grant register; reset points it at IF so DM wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_dm_q <= 1'b0;
      end else begin
         last_dm_q <= last_dm_d;
      end
   end
`else
   assign grant_dm_s = bus.dm_req;
`endif

   // Next-state and output-register logic for the grant/busy/response FSM.
   always_comb begin
      state_d     = state_q;
      cnt_d       = {CNT_W{1'b0}};
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      if_ack_d    = 1'b0;
      dm_ack_d    = 1'b0;
      bus_err_d   = 1'b0;
`ifdef ARB_RR_EN
      last_dm_d   = last_dm_q;
`endif
      case (state_q)
         IDLE: begin
            if (grant_dm_s) begin
               mem_req_d   = 1'b1;
               mem_we_d    = bus.dm_we;
               mem_addr_d  = bus.dm_addr;
               mem_wdata_d = bus.dm_wdata;
               state_d     = BUSY_DM;
`ifdef ARB_RR_EN
               last_dm_d   = 1'b1;
`endif
            end else if (bus.if_req) begin
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = bus.if_addr;
               state_d     = BUSY_IF;
`ifdef ARB_RR_EN
               last_dm_d   = 1'b0;
`endif
            end else begin
               state_d     = IDLE;
            end
         end
         BUSY_IF, BUSY_DM: begin
            // A real ack in the final watchdog cycle still wins over the abort.
            if (bus.mem_ack || (cnt_q == CNT_LAST)) begin
               mem_req_d = 1'b0;
               state_d   = RESP;
               bus_err_d = ~bus.mem_ack;
               if (state_q == BUSY_DM) begin
                  dm_ack_d = 1'b1;
                  if (bus.mem_ack && !mem_we_q) begin
                     dm_rdata_d = bus.mem_rdata;
                  end else begin
                     dm_rdata_d = dm_rdata_q;
                  end
               end else begin
                  if_ack_d = 1'b1;
                  if (bus.mem_ack) begin
                     if_rdata_d = bus.mem_rdata;
                  end else begin
                     if_rdata_d = if_rdata_q;
                  end
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         RESP: begin
            // Ack cycle: a still-high request is deliberately not re-sampled.
            state_d = IDLE;
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {ADDR_W{1'b0}};
         mem_wdata_q <= {DATA_W{1'b0}};
         if_rdata_q  <= {DATA_W{1'b0}};
         dm_rdata_q  <= {DATA_W{1'b0}};
         if_ack_q    <= 1'b0;
         dm_ack_q    <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         if_ack_q    <= if_ack_d;
         dm_ack_q    <= dm_ack_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.if_ack    = if_ack_q;
   assign bus.dm_ack    = dm_ack_q;
   assign bus.bus_err   = bus_err_q;
   // Stalls are combinational so the hazard unit releases in the ack cycle.
   assign bus.if_stall  = bus.if_req & ~if_ack_q;
   assign bus.dm_stall  = bus.dm_req & ~dm_ack_q;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch port and data-memory port.
- Sits between the fetch/MEM stages and the memory model.
- Sequences each access through a grant/busy/response FSM and raises per-port stall signals, which feed the hazard logic to freeze the PC, IF/ID and EX/MEM.
- Includes a watchdog that aborts hung memory transactions.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
TIMEOUT, 16, max BUSY cycles without mem_ack before abort (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
if_req  input  1  fetch request, held until if_ack
if_addr  input  ADDR_W  fetch address
if_rdata  output  DATA_W  fetched instruction, valid with if_ack
if_ack  output  1  one-cycle completion pulse, fetch port
if_stall  output  1  if_req & ~if_ack (combinational)
dm_req  input  1  data request, held until dm_ack
dm_we  input  1  1 = store, 0 = load
dm_addr  input  ADDR_W  data address
dm_wdata  input  DATA_W  store data
dm_rdata  output  DATA_W  load data, valid with dm_ack
dm_ack  output  1  one-cycle completion pulse, data port
dm_stall  output  1  dm_req & ~dm_ack (combinational)
mem_req  output  1  memory request, held until mem_ack or abort
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid with mem_ack
mem_ack  input  1  memory completion, one-cycle pulse
bus_err  output  1  pulses with the ack of an aborted access

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: FSM=IDLE; mem_req, mem_we, if_ack, dm_ack, bus_err = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0; wait counter = 0; last_grant = IF.
- FSM states: IDLE, BUSY_IF, BUSY_DM, RESP.
- IDLE:
  - Samples requests.
  - dm_req=1 → latch dm_addr, dm_wdata and dm_we into the mem_* registers; go BUSY_DM.
  - Otherwise if_req=1 → latch if_addr, with mem_we=0; go BUSY_IF.
  - Nothing requested → stay IDLE.
  - Fixed priority: data wins when both ports request.
- BUSY_x:
  - mem_req=1; mem_addr, mem_wdata and mem_we are stable and unaffected by requester changes.
  - Wait counter increments every BUSY cycle.
  - mem_ack=1 → capture mem_rdata into x_rdata (reads only; unchanged on stores); go RESP.
  - Counter reaches TIMEOUT-1 without mem_ack → abort: x_rdata unchanged, set err flag, go RESP.
  - mem_req drops on the exit edge.
- RESP:
  - Exactly one cycle.
  - x_ack=1 for the granted port only; bus_err=1 if aborted.
  - No new grant is made in this cycle, so a still-high req is not re-granted.
  - Then IDLE; counter cleared.
- Latency: req sampled at edge N, memory acks in the first BUSY cycle → x_ack high during the cycle after edge N+1. Minimum issue interval is 3 cycles per access.
- Each ack pulse lasts exactly one cycle. Both acks are never high together.
- mem_ack outside BUSY is ignored.
- rst mid-transaction:
  - Next edge forces IDLE and drops mem_req.
  - No ack or bus_err is produced; the access is lost and the requester re-issues after reset.
- last_grant is updated at each grant (used by the optional feature only).

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: when both ports request in IDLE, grant the port opposite last_grant. After reset DM wins first because last_grant=IF. Single requests behave the same as without the macro.
- Undefined: fixed data-priority as above; last_grant register may be omitted.

Test Plan:
1. Fetch only: if_req=1, if_addr=0x40; memory acks 1 cycle after mem_req with mem_rdata=0x8C010004 → mem_addr=0x40, mem_we=0; if_ack pulses one cycle with if_rdata=0x8C010004; if_stall high until then.
2. Simultaneous: if_req and dm_req both high, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF → DM served first (mem_we=1, mem_wdata=0xDEADBEEF); IF served immediately after; dm_rdata unchanged.
3. ARB_RR_EN: both ports request continuously for 4 accesses → grant order DM, IF, DM, IF. Without the macro: DM, DM, DM, DM while dm_req stays high.
4. Timeout: dm_req load, mem_ack never asserted, TIMEOUT=16 → mem_req high exactly 16 cycles; dm_ack and bus_err pulse together; dm_rdata keeps its prior value.
5. Mid-op reset: rst asserted during BUSY_IF → next cycle mem_req=0, FSM IDLE, no if_ack or bus_err; a new if_req after reset completes normally.
6. Address change while busy: dm_addr changes from 0x10 to 0x20 during BUSY_DM → mem_addr stays 0x10 until the ack.
